// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 device-to-host receiver; each scan-code byte is handed over on the kbd_rda/clear_kbd handshake.
// Latency: SYNC_STAGES+FILTER_LEN+1 clk from the stop-bit ps2_clk fall at the pin to kbd_rda=1.
// Backpressure: none toward the keyboard; an unconsumed byte is overwritten and flagged on overrun. Macro KBD_PARITY_CHECK_EN adds odd-parity checking.
module ps2_kbd_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kbd_databus,
    output logic       kbd_rda,
    input  logic       clear_kbd,
    output logic       frame_err,
    output logic       overrun
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [FW-1:0]          flt_cnt;
    logic                   flt_clk;
    logic                   flt_clk_q;
    logic                   fall;
    logic                   data_bit;
    logic                   timeout;
    logic                   deliver;
    logic                   err;
    state_t                 state;
    state_t                 state_d;
    logic [7:0]             shift_q;
    logic [7:0]             shift_d;
    logic [2:0]             bit_cnt;
    logic [2:0]             bit_cnt_d;
    logic [TW-1:0]          tcnt;
    logic                   par_ok;

`ifdef KBD_PARITY_CHECK_EN
    logic par_q;
    logic par_d;
    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    assign data_bit = dat_sync[SYNC_STAGES-1];
    assign fall     = flt_clk_q & ~flt_clk;
    assign timeout  = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // The filtered clock only moves after FILTER_LEN agreeing samples, so short glitches never reach the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            dat_sync  <= '1;
            flt_cnt   <= '0;
            flt_clk   <= 1'b1;
            flt_clk_q <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            flt_clk_q <= flt_clk;
            if (clk_sync[SYNC_STAGES-1] != flt_clk) begin
                if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                    flt_clk <= ~flt_clk;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + FW'(1);
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt;
        deliver   = 1'b0;
        err       = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        if (timeout) begin
            state_d = IDLE;
            err     = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                    par_d   = data_bit;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_bit && par_ok) begin
                        deliver = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            tcnt    <= '0;
`ifdef KBD_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift_q <= shift_d;
            bit_cnt <= bit_cnt_d;
`ifdef KBD_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
            if (state == IDLE || fall) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // A delivery in the same cycle as clear_kbd keeps kbd_rda high and drops overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_databus <= 8'h00;
            kbd_rda     <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= err;
            if (deliver) begin
                kbd_databus <= shift_q;
                kbd_rda     <= 1'b1;
                if (kbd_rda) begin
                    overrun <= ~clear_kbd;
                end
            end else if (clear_kbd && kbd_rda) begin
                kbd_rda <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: frame-level reference model checked every cycle, plus hand-computed scenario checks.
module tb_ps2_kbd_rx;

    localparam int SYNC = 2;
    localparam int FLT  = 8;
    localparam int TMO  = 300;
    localparam int LAT  = SYNC + FLT + 1;
    localparam int H    = 40;
`ifdef KBD_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct {
        int         when;
        logic       ok;
        logic [7:0] byt;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] kbd_databus;
    logic       kbd_rda;
    logic       clear_kbd;
    logic       frame_err;
    logic       overrun;

    ps2_kbd_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kbd_databus(kbd_databus), .kbd_rda(kbd_rda), .clear_kbd(clear_kbd),
        .frame_err(frame_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         clr_at = -10;
    int         last_fall = 0;
    int         n_ferr = 0;
    int         ferr_cyc = 0;
    int         rda_rise = 0;
    logic       rda_seen = 1'b0;
    logic       rda_e = 1'b0;
    logic       ovr_e = 1'b0;
    logic       ferr_e = 1'b0;
    logic [7:0] bus_e = 8'h00;
    ev_t        ev_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clk cycle: advance the frame-level model past the posedge just seen, compare, then drive clear_kbd.
    task automatic tick();
        logic       dlv;
        logic [7:0] nb;
        ev_t        e;
        @(negedge clk);
        cyc++;
        ferr_e = 1'b0;
        if (!rst_n) begin
            rda_e = 1'b0;
            ovr_e = 1'b0;
            bus_e = 8'h00;
            ev_q.delete();
        end else begin
            dlv = 1'b0;
            nb  = 8'h00;
            while (ev_q.size() > 0 && ev_q[0].when <= cyc) begin
                e = ev_q.pop_front();
                if (e.ok) begin
                    dlv = 1'b1;
                    nb  = e.byt;
                end else begin
                    ferr_e = 1'b1;
                end
            end
            if (dlv) begin
                if (rda_e) ovr_e = !clear_kbd;
                rda_e = 1'b1;
                bus_e = nb;
            end else if (clear_kbd && rda_e) begin
                rda_e = 1'b0;
                ovr_e = 1'b0;
            end
        end
        check("cyc_rda", kbd_rda, rda_e);
        check("cyc_databus", kbd_databus, bus_e);
        check("cyc_overrun", overrun, ovr_e);
        check("cyc_frame_err", frame_err, ferr_e);
        if (frame_err) begin
            n_ferr++;
            ferr_cyc = cyc;
        end
        if (kbd_rda && !rda_seen) rda_rise = cyc;
        rda_seen  = kbd_rda;
        clear_kbd = (cyc == clr_at);
    endtask

    // kind: 0 none, 1 byte delivered, 2 frame error, 3 timeout error, 4 delivered with coincident clear_kbd
    task automatic ps2_bit(input logic b, input int kind, input logic [7:0] byt);
        ev_t e;
        repeat (H/2) tick();
        ps2_data = b;
        repeat (H/2) tick();
        ps2_clk   = 1'b0;
        last_fall = cyc;
        e.byt = byt;
        e.ok  = (kind == 1 || kind == 4);
        e.when = (kind == 3) ? cyc + LAT + TMO : cyc + LAT;
        if (kind != 0) ev_q.push_back(e);
        if (kind == 4) clr_at = cyc + LAT - 1;
        repeat (H) tick();
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] byt, input logic par, input logic stop, input logic clr_same);
        logic [10:0] f;
        logic        ok;
        f  = {stop, par, byt, 1'b0};
        ok = stop && (!PCHK || (^{byt, par}));
        for (int i = 0; i < 10; i++) ps2_bit(f[i], 0, 8'h00);
        ps2_bit(f[10], ok ? (clr_same ? 4 : 1) : 2, byt);
        repeat (20) tick();
    endtask

    task automatic pulse_clear();
        clr_at = cyc + 1;
        repeat (3) tick();
    endtask

    initial begin
        int f0;
        rst_n     = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        clear_kbd = 1'b0;
        repeat (5) tick();
        check("reset_databus", kbd_databus, 8'h00);
        check("reset_rda", kbd_rda, 1'b0);
        #2 rst_n = 1'b1;
        repeat (10) tick();
        check("idle_overrun", overrun, 1'b0);
        check("idle_frame_err_count", n_ferr, 0);

        send_frame(8'h1D, 1'b1, 1'b1, 1'b0);
        check("s1_databus", kbd_databus, 8'h1D);
        check("s1_rda", kbd_rda, 1'b1);
        check("s1_latency", rda_rise - last_fall, 11);
        check("s1_no_frame_err", n_ferr, 0);
        pulse_clear();
        check("s1_clear_rda", kbd_rda, 1'b0);
        check("s1_clear_holds_bus", kbd_databus, 8'h1D);

        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("s2_databus", kbd_databus, 8'h1C);
        check("s2_rda", kbd_rda, 1'b1);
        check("s2_overrun", overrun, 1'b1);
        pulse_clear();
        check("s2_clear_rda", kbd_rda, 1'b0);
        check("s2_clear_overrun", overrun, 1'b0);

        f0 = n_ferr;
        send_frame(8'h23, 1'b1, 1'b1, 1'b0);
`ifdef KBD_PARITY_CHECK_EN
        check("s3_parity_err", n_ferr - f0, 1);
        check("s3_rda", kbd_rda, 1'b0);
`else
        check("s3_databus", kbd_databus, 8'h23);
        check("s3_rda", kbd_rda, 1'b1);
        pulse_clear();
`endif

        f0 = n_ferr;
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        check("s4_stop_err", n_ferr - f0, 1);
        check("s4_rda", kbd_rda, 1'b0);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        check("s4_good_rda", kbd_rda, 1'b1);
        check("s4_good_databus", kbd_databus, 8'h12);
        pulse_clear();

        f0 = n_ferr;
        ps2_bit(1'b0, 0, 8'h00);
        ps2_bit(1'b1, 0, 8'h00);
        ps2_bit(1'b1, 0, 8'h00);
        ps2_bit(1'b0, 0, 8'h00);
        ps2_bit(1'b1, 3, 8'h00);
        repeat (TMO + 100) tick();
        check("s5_timeout_err", n_ferr - f0, 1);
        check("s5_timeout_gap", ferr_cyc - last_fall, 311);
        check("s5_rda", kbd_rda, 1'b0);
        send_frame(8'h1B, 1'b1, 1'b1, 1'b0);
        check("s5_databus", kbd_databus, 8'h1B);
        check("s5_rda_after", kbd_rda, 1'b1);

        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        check("s7_overrun", overrun, 1'b1);
        send_frame(8'h66, 1'b1, 1'b1, 1'b1);
        check("s7_same_cycle_databus", kbd_databus, 8'h66);
        check("s7_same_cycle_rda", kbd_rda, 1'b1);
        check("s7_same_cycle_overrun", overrun, 1'b0);
        pulse_clear();

        f0 = n_ferr;
        ps2_data = 1'b0;
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            repeat (3) tick();
            ps2_clk = 1'b1;
            repeat (15) tick();
        end
        ps2_data = 1'b1;
        ps2_bit(1'b0, 0, 8'h00);
        ps2_bit(1'b1, 0, 8'h00);
        ps2_bit(1'b0, 0, 8'h00);
        ps2_bit(1'b1, 0, 8'h00);
        #2 rst_n = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b1;
        ps2_data = 1'b1;
        repeat (5) tick();
        ps2_clk = 1'b0;
        repeat (H) tick();
        ps2_clk = 1'b1;
        repeat (TMO + 50) tick();
        check("s6_no_frame_err", n_ferr - f0, 0);
        check("s6_rda", kbd_rda, 1'b0);
        send_frame(8'h1D, 1'b1, 1'b1, 1'b0);
        check("s6_databus", kbd_databus, 8'h1D);
        check("s6_rda_after", kbd_rda, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
